// File: rtl/cop0_if.sv
// Core-to-COP0 signal bundle. The core drives the master side; cop0 sits on the slave side.
interface cop0_if;
  logic [31:0] pc;
  logic [4:0]  hw_int;
  logic        syscall;
  logic        brk;
  logic        ovf;
  logic        ri;
  logic        eret;
  logic        mtc0;
  logic [4:0]  sel;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        cop_trap;
  logic [31:0] cop_addr;
  logic        exl;

  modport master (
    output pc, hw_int, syscall, brk, ovf, ri, eret, mtc0, sel, wr_data,
    input  rd_data, cop_trap, cop_addr, exl
  );

  modport slave (
    input  pc, hw_int, syscall, brk, ovf, ri, eret, mtc0, sel, wr_data,
    output rd_data, cop_trap, cop_addr, exl
  );
endinterface

// File: rtl/cop0.sv
// Coprocessor-0: Status/Cause/EPC/Count/Compare, interrupt and exception detection,
// and the trap/redirect request for the single-cycle core's COP0 PC path.
module cop0 #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080,
  parameter logic [31:0] COMPARE_RST  = 32'hFFFF_FFFF
) (
  input logic   clk,
  input logic   rest,
  cop0_if.slave bus
);

  localparam logic [4:0] SelCount   = 5'd9;
  localparam logic [4:0] SelCompare = 5'd11;
  localparam logic [4:0] SelStatus  = 5'd12;
  localparam logic [4:0] SelCause   = 5'd13;
  localparam logic [4:0] SelEpc     = 5'd14;

  logic [7:0]  im_q;
  logic        exl_q;
  logic        ie_q;
  logic [4:0]  exc_code_q;
  logic [1:0]  ip_sw_q;
  logic [4:0]  ip_hw_q;
  logic        timer_ip_q;
  logic [31:0] epc_q;
  logic [31:0] count_q;
  logic [31:0] compare_q;
  logic [4:0]  sync1_q;
  logic [4:0]  sync2_q;

  logic [7:0]  ip;
  logic        int_pending;
  logic        exc_take;
  logic [4:0]  exc_code;
  logic        eret_take;
  logic        wr_en;
  logic [31:0] status_rd;
  logic [31:0] cause_rd;

  assign ip          = {timer_ip_q, ip_hw_q, ip_sw_q};
  assign int_pending = ie_q & ~exl_q & (|(ip & im_q));
  assign status_rd   = {16'b0, im_q, 6'b0, exl_q, ie_q};
  assign cause_rd    = {16'b0, ip, 1'b0, exc_code_q, 2'b0};

  always_comb begin
    exc_take = int_pending | bus.ri | bus.ovf | bus.syscall | bus.brk;
    if (int_pending)      exc_code = 5'd0;
    else if (bus.ri)      exc_code = 5'd10;
    else if (bus.ovf)     exc_code = 5'd12;
    else if (bus.syscall) exc_code = 5'd8;
    else                  exc_code = 5'd9;
    eret_take = bus.eret & ~exc_take;
    // A trapping instruction is killed, so its register write never lands.
    wr_en     = bus.mtc0 & ~exc_take & ~bus.eret;
  end

  assign bus.cop_trap = exc_take | bus.eret;
  assign bus.cop_addr = eret_take ? epc_q : HANDLER_ADDR;
  assign bus.exl      = exl_q;

  always_comb begin
    bus.rd_data = 32'b0;
    case (bus.sel)
      SelCount:   bus.rd_data = count_q;
      SelCompare: bus.rd_data = compare_q;
      SelStatus:  bus.rd_data = status_rd;
      SelCause:   bus.rd_data = cause_rd;
      SelEpc:     bus.rd_data = epc_q;
      default:    bus.rd_data = 32'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      im_q       <= 8'b0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      exc_code_q <= 5'b0;
      ip_sw_q    <= 2'b0;
      ip_hw_q    <= 5'b0;
      timer_ip_q <= 1'b0;
      epc_q      <= 32'b0;
      count_q    <= 32'b0;
      compare_q  <= COMPARE_RST;
      sync1_q    <= 5'b0;
      sync2_q    <= 5'b0;
    end else begin
      sync1_q <= bus.hw_int;
      sync2_q <= sync1_q;
      ip_hw_q <= sync2_q;

      if (wr_en && bus.sel == SelCount) count_q <= bus.wr_data;
      else                              count_q <= count_q + 32'd1;

      // Rewriting Compare acknowledges the timer; the clear beats a same-edge match.
      if (wr_en && bus.sel == SelCompare) begin
        compare_q  <= bus.wr_data;
        timer_ip_q <= 1'b0;
      end else if (count_q == compare_q) begin
        timer_ip_q <= 1'b1;
      end

      if (exc_take) begin
        exc_code_q <= exc_code;
        exl_q      <= 1'b1;
        if (!exl_q) epc_q <= bus.pc;
      end else if (eret_take) begin
        exl_q <= 1'b0;
      end else if (wr_en) begin
        case (bus.sel)
          SelStatus: begin
            im_q  <= bus.wr_data[15:8];
            exl_q <= bus.wr_data[1];
            ie_q  <= bus.wr_data[0];
          end
          SelCause: ip_sw_q <= bus.wr_data[9:8];
          SelEpc:   epc_q   <= bus.wr_data;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cop0.sv
// Directed bench for cop0: reset, syscall/eret, hw interrupt latency, timer, collisions.
module tb_cop0;
  logic clk;
  logic rest;
  int   n_checks;
  int   n_fail;
  logic [31:0] v;

  cop0_if bus ();

  cop0 #(
    .HANDLER_ADDR(32'h0000_0080),
    .COMPARE_RST (32'hFFFF_FFFF)
  ) dut (
    .clk (clk),
    .rest(rest),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] s, output logic [31:0] val);
    bus.sel = s;
    #1;
    val = bus.rd_data;
  endtask

  task automatic wr(input logic [4:0] s, input logic [31:0] d);
    bus.mtc0    = 1'b1;
    bus.sel     = s;
    bus.wr_data = d;
    tick();
    bus.mtc0    = 1'b0;
  endtask

  task automatic test_reset();
    rest = 1'b1;
    tick();
    tick();
    rd(5'd12, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_status got %h want %h", v, 32'h0); end
    rd(5'd13, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_cause got %h want %h", v, 32'h0); end
    rd(5'd14, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_epc got %h want %h", v, 32'h0); end
    rd(5'd9, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_count got %h want %h", v, 32'h0); end
    rd(5'd11, v);
    n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL reset_compare got %h want %h", v, 32'hFFFF_FFFF); end
    n_checks++; if (bus.cop_trap !== 1'b0 || bus.exl !== 1'b0) begin n_fail++; $display("FAIL reset_trap_exl got %b%b want 00", bus.cop_trap, bus.exl); end
    rd(5'd5, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL unlisted_sel got %h want %h", v, 32'h0); end
    rest = 1'b0;
    tick();
    rd(5'd9, v);
    n_checks++; if (v !== 32'h1) begin n_fail++; $display("FAIL count_after_reset got %h want %h", v, 32'h1); end
  endtask

  task automatic test_syscall();
    bus.pc = 32'h40;
    bus.syscall = 1'b1;
    #1;
    n_checks++; if (bus.cop_trap !== 1'b1) begin n_fail++; $display("FAIL sys_trap got %b want 1", bus.cop_trap); end
    n_checks++; if (bus.cop_addr !== 32'h80) begin n_fail++; $display("FAIL sys_addr got %h want %h", bus.cop_addr, 32'h80); end
    tick();
    bus.syscall = 1'b0;
    rd(5'd14, v);
    n_checks++; if (v !== 32'h40) begin n_fail++; $display("FAIL sys_epc got %h want %h", v, 32'h40); end
    rd(5'd13, v);
    n_checks++; if (v !== 32'h20) begin n_fail++; $display("FAIL sys_cause got %h want %h", v, 32'h20); end
    n_checks++; if (bus.exl !== 1'b1) begin n_fail++; $display("FAIL sys_exl got %b want 1", bus.exl); end
    bus.eret = 1'b1;
    #1;
    n_checks++; if (bus.cop_trap !== 1'b1 || bus.cop_addr !== 32'h40) begin n_fail++; $display("FAIL eret_redirect got %b/%h want 1/%h", bus.cop_trap, bus.cop_addr, 32'h40); end
    tick();
    bus.eret = 1'b0;
    #1;
    n_checks++; if (bus.exl !== 1'b0) begin n_fail++; $display("FAIL eret_exl got %b want 0", bus.exl); end
  endtask

  task automatic test_hw_int();
    wr(5'd12, 32'h0000_0401);
    rd(5'd12, v);
    n_checks++; if (v !== 32'h401) begin n_fail++; $display("FAIL hw_status got %h want %h", v, 32'h401); end
    bus.pc = 32'h100;
    bus.hw_int = 5'b00001;
    #1;
    n_checks++; if (bus.cop_trap !== 1'b0) begin n_fail++; $display("FAIL hw_trap_pre got %b want 0", bus.cop_trap); end
    tick(); // edge N
    n_checks++; if (bus.cop_trap !== 1'b0) begin n_fail++; $display("FAIL hw_trap_n got %b want 0", bus.cop_trap); end
    tick(); // edge N+1
    rd(5'd13, v);
    n_checks++; if (bus.cop_trap !== 1'b0 || v[10] !== 1'b0) begin n_fail++; $display("FAIL hw_trap_n1 got %b/%b want 0/0", bus.cop_trap, v[10]); end
    tick(); // edge N+2
    rd(5'd13, v);
    n_checks++; if (bus.cop_trap !== 1'b1 || v[10] !== 1'b1) begin n_fail++; $display("FAIL hw_trap_n2 got %b/%b want 1/1", bus.cop_trap, v[10]); end
    n_checks++; if (bus.cop_addr !== 32'h80) begin n_fail++; $display("FAIL hw_addr got %h want %h", bus.cop_addr, 32'h80); end
    tick();
    rd(5'd13, v);
    n_checks++; if (v !== 32'h400) begin n_fail++; $display("FAIL hw_cause got %h want %h", v, 32'h400); end
    rd(5'd14, v);
    n_checks++; if (v !== 32'h100 || bus.exl !== 1'b1) begin n_fail++; $display("FAIL hw_epc_exl got %h/%b want %h/1", v, bus.exl, 32'h100); end
    // Interrupt still asserted but masked by EXL.
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (bus.cop_trap !== 1'b0) begin n_fail++; $display("FAIL hw_exl_masked got %b want 0", bus.cop_trap); end
    end
    bus.hw_int = 5'b0;
    repeat (3) tick();
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    #1;
    n_checks++; if (bus.exl !== 1'b0 || bus.cop_trap !== 1'b0) begin n_fail++; $display("FAIL hw_after_eret got %b/%b want 0/0", bus.exl, bus.cop_trap); end
  endtask

  task automatic test_timer();
    wr(5'd11, 32'd5);
    wr(5'd9, 32'd0);
    rd(5'd9, v);
    n_checks++; if (v !== 32'd0) begin n_fail++; $display("FAIL tmr_count0 got %h want 0", v); end
    repeat (5) tick();
    rd(5'd13, v);
    n_checks++; if (v[15] !== 1'b0) begin n_fail++; $display("FAIL tmr_early got %b want 0", v[15]); end
    tick();
    rd(5'd13, v);
    n_checks++; if (v !== 32'h8000) begin n_fail++; $display("FAIL tmr_set got %h want %h", v, 32'h8000); end
    n_checks++; if (bus.cop_trap !== 1'b0) begin n_fail++; $display("FAIL tmr_unmasked got %b want 0", bus.cop_trap); end
    wr(5'd12, 32'h0000_8001);
    bus.pc = 32'h200;
    #1;
    n_checks++; if (bus.cop_trap !== 1'b1) begin n_fail++; $display("FAIL tmr_trap got %b want 1", bus.cop_trap); end
    tick();
    rd(5'd14, v);
    n_checks++; if (v !== 32'h200 || bus.exl !== 1'b1) begin n_fail++; $display("FAIL tmr_epc got %h/%b want %h/1", v, bus.exl, 32'h200); end
    wr(5'd11, 32'd100);
    rd(5'd13, v);
    n_checks++; if (v[15] !== 1'b0) begin n_fail++; $display("FAIL tmr_clear got %b want 0", v[15]); end
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    #1;
    n_checks++; if (bus.exl !== 1'b0 || bus.cop_trap !== 1'b0) begin n_fail++; $display("FAIL tmr_after_eret got %b/%b want 0/0", bus.exl, bus.cop_trap); end
  endtask

  task automatic test_collisions();
    wr(5'd11, 32'hFFFF_FFFF);
    bus.pc = 32'h300;
    bus.ovf = 1'b1;
    bus.syscall = 1'b1;
    bus.mtc0 = 1'b1;
    bus.sel = 5'd12;
    bus.wr_data = 32'h0000_FF01;
    #1;
    n_checks++; if (bus.cop_trap !== 1'b1 || bus.cop_addr !== 32'h80) begin n_fail++; $display("FAIL col_trap got %b/%h want 1/%h", bus.cop_trap, bus.cop_addr, 32'h80); end
    tick();
    bus.ovf = 1'b0;
    bus.syscall = 1'b0;
    bus.mtc0 = 1'b0;
    rd(5'd13, v);
    n_checks++; if (v !== 32'h30) begin n_fail++; $display("FAIL col_ovf_code got %h want %h", v, 32'h30); end
    rd(5'd12, v);
    n_checks++; if (v !== 32'h8003) begin n_fail++; $display("FAIL col_status_drop got %h want %h", v, 32'h8003); end
    bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
    wr(5'd12, 32'h0000_0101);
    wr(5'd13, 32'h0000_0100);
    bus.pc = 32'h40;
    bus.ri = 1'b1;
    #1;
    n_checks++; if (bus.cop_trap !== 1'b1) begin n_fail++; $display("FAIL col_int_ri_trap got %b want 1", bus.cop_trap); end
    tick();
    rd(5'd13, v);
    n_checks++; if (v !== 32'h100) begin n_fail++; $display("FAIL col_int_wins got %h want %h", v, 32'h100); end
    bus.pc = 32'h84;
    #1;
    n_checks++; if (bus.cop_trap !== 1'b1) begin n_fail++; $display("FAIL nest_trap got %b want 1", bus.cop_trap); end
    tick();
    bus.ri = 1'b0;
    rd(5'd14, v);
    n_checks++; if (v !== 32'h40) begin n_fail++; $display("FAIL nest_epc got %h want %h", v, 32'h40); end
    rd(5'd13, v);
    n_checks++; if (v !== 32'h128 || bus.exl !== 1'b1) begin n_fail++; $display("FAIL nest_cause got %h/%b want %h/1", v, bus.exl, 32'h128); end
  endtask

  task automatic test_count_wrap();
    wr(5'd9, 32'hFFFF_FFFF);
    rd(5'd9, v);
    n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_pre got %h want %h", v, 32'hFFFF_FFFF); end
    tick();
    rd(5'd9, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL wrap got %h want 0", v); end
    rd(5'd13, v);
    n_checks++; if (v !== 32'h8128) begin n_fail++; $display("FAIL wrap_timer got %h want %h", v, 32'h8128); end
  endtask

  task automatic test_reset_mid();
    rest = 1'b1;
    tick();
    rd(5'd13, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL midrst_cause got %h want 0", v); end
    n_checks++; if (bus.exl !== 1'b0 || bus.cop_trap !== 1'b0) begin n_fail++; $display("FAIL midrst_exl_trap got %b/%b want 0/0", bus.exl, bus.cop_trap); end
    rd(5'd11, v);
    n_checks++; if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL midrst_compare got %h want %h", v, 32'hFFFF_FFFF); end
    rest = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rest = 1'b0;
    bus.pc = 32'h0;
    bus.hw_int = 5'b0;
    bus.syscall = 1'b0;
    bus.brk = 1'b0;
    bus.ovf = 1'b0;
    bus.ri = 1'b0;
    bus.eret = 1'b0;
    bus.mtc0 = 1'b0;
    bus.sel = 5'd0;
    bus.wr_data = 32'h0;
    test_reset();
    test_syscall();
    test_hw_int();
    test_timer();
    test_collisions();
    test_count_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
